// File: rtl/fact_bus_if.sv
// Memory-mapped register front end for the factorial core: N/GO/STATUS/RESULT
// decode, go pulse generation, sticky status and result capture. FACT_IRQ_EN adds irq_en/irq.
module fact_bus_if #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [1:0]       addr_i,
    input  logic [WIDTH-1:0] wd_i,
    output logic [WIDTH-1:0] rd_o,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] core_n_o,
    output logic             core_go_o,
    input  logic             core_done_i,
    input  logic             core_err_i,
    input  logic [WIDTH-1:0] core_nf_i,
    output logic             irq_o
);

    // state  | meaning
    // IDLE   | waiting for a go write; N writable
    // START  | core_go asserted for this single cycle
    // WAIT   | core running; sampling core_done/core_err
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] A_N      = 2'd0;
    localparam logic [1:0] A_GO     = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_RESULT = 2'd3;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             rd_valid_q, rd_valid_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] rdata;
    logic             go_acc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            result_q   <= result_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        result_d   = result_q;
        done_d     = done_q;
        err_d      = err_q;
        irq_en_d   = irq_en_q;
        irq_d      = irq_q;
        rd_d       = rd_q;
        rd_valid_d = re_i;
        go_acc     = we_i && (addr_i == A_GO) && wd_i[0] && (state_q == S_IDLE);

        status    = '0;
        status[0] = done_q;
        status[1] = err_q;
        status[2] = (state_q != S_IDLE);
`ifdef FACT_IRQ_EN
        status[8] = irq_en_q;
`endif

        // Mux uses current register values, so a same-cycle write returns the old data.
        rdata = '0;
        case (addr_i)
            A_N:      rdata = n_q;
            A_GO:     rdata = '0;
            A_STATUS: rdata = status;
            A_RESULT: rdata = result_q;
            default:  rdata = '0;
        endcase
        if (re_i) begin
            rd_d = rdata;
        end

        case (state_q)
            S_IDLE: begin
                if (we_i && (addr_i == A_N)) begin
                    n_d = wd_i;
                end
                if (go_acc) begin
                    state_d = S_START;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_err_i) begin
                    state_d  = S_IDLE;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    result_d = '0;
                end else if (core_done_i) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    result_d = core_nf_i;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef FACT_IRQ_EN
        if (we_i && (addr_i == A_STATUS)) begin
            irq_en_d = wd_i[8];
        end
        // Built from next-state values so a go or irq_en=0 clears irq on the same edge.
        irq_d = irq_en_d & done_d;
`else
        irq_en_d = 1'b0;
        irq_d    = 1'b0;
`endif
    end

    assign rd_o       = rd_q;
    assign rd_valid_o = rd_valid_q;
    assign core_n_o   = n_q;
    assign core_go_o  = (state_q == S_START);
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_fact_bus_if.sv
// Directed self-checking bench for fact_bus_if; the core is emulated by hand-driven
// done/err/nf with hand-computed results. Irq checks follow FACT_IRQ_EN.
module tb_fact_bus_if;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             we;
    logic             re;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;
    logic             rd_valid;
    logic [WIDTH-1:0] core_n;
    logic             core_go;
    logic             core_done;
    logic             core_err;
    logic [WIDTH-1:0] core_nf;
    logic             irq;

    int n_checks = 0;
    int n_fail   = 0;
    int go_cnt   = 0;
    int go_base;
    logic [WIDTH-1:0] rdata;

    fact_bus_if #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .we_i        (we),
        .re_i        (re),
        .addr_i      (addr),
        .wd_i        (wd),
        .rd_o        (rd),
        .rd_valid_o  (rd_valid),
        .core_n_o    (core_n),
        .core_go_o   (core_go),
        .core_done_i (core_done),
        .core_err_i  (core_err),
        .core_nf_i   (core_nf),
        .irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_go) go_cnt++;
    end

    task automatic check_val(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [1:0] a, input logic [WIDTH-1:0] d);
        we = 1'b1; addr = a; wd = d;
        @(negedge clk);
        we = 1'b0; wd = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [WIDTH-1:0] d);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        check_val("rd_valid_after_re", {31'd0, rd_valid}, 32'd1);
        d = rd;
    endtask

    task automatic core_finish(input logic err, input logic [WIDTH-1:0] nf);
        core_done = 1'b1; core_err = err; core_nf = nf;
        @(negedge clk);
        core_done = 1'b0; core_err = 1'b0; core_nf = '0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wd = '0;
        core_done = 1'b0; core_err = 1'b0; core_nf = '0;
        #1;
        check_val("reset_rd", rd, 32'd0);
        check_val("reset_go", {31'd0, core_go}, 32'd0);
        check_val("reset_core_n", core_n, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_read(2'd2, rdata); check_val("reset_status", rdata, 32'd0);

        // N=5 -> 120
        bus_write(2'd0, 32'd5);
        check_val("core_n_5", core_n, 32'd5);
        go_base = go_cnt;
        bus_write(2'd1, 32'd1);
        check_val("go_pulse_high", {31'd0, core_go}, 32'd1);
        @(negedge clk);
        check_val("go_pulse_low", {31'd0, core_go}, 32'd0);
        bus_read(2'd2, rdata); check_val("status_busy", rdata, 32'h4);
        @(negedge clk);
        check_val("rd_valid_drops", {31'd0, rd_valid}, 32'd0);
        check_val("rd_holds", rd, 32'h4);
        core_finish(1'b0, 32'd120);
        bus_read(2'd2, rdata); check_val("status_done", rdata, 32'h1);
        bus_read(2'd3, rdata); check_val("result_120", rdata, 32'd120);
        bus_read(2'd1, rdata); check_val("go_reads_zero", rdata, 32'd0);
        check_val("go_count_run1", go_cnt - go_base, 32'd1);

        // N=13 overflow, err and done both high: err wins
        bus_write(2'd0, 32'd13);
        bus_write(2'd1, 32'd1);
        @(negedge clk);
        core_finish(1'b1, 32'hDEAD);
        bus_read(2'd2, rdata); check_val("status_err", rdata, 32'h3);
        bus_read(2'd3, rdata); check_val("result_err", rdata, 32'd0);

        // N=3 -> 6, sticky err cleared by go
        bus_write(2'd0, 32'd3);
        bus_write(2'd1, 32'd1);
        bus_read(2'd2, rdata); check_val("status_cleared", rdata, 32'h4);
        core_finish(1'b0, 32'd6);
        bus_read(2'd2, rdata); check_val("status_after_3", rdata, 32'h1);
        bus_read(2'd3, rdata); check_val("result_6", rdata, 32'd6);

        // GO with wd[0]=0 does nothing
        go_base = go_cnt;
        bus_write(2'd1, 32'h2);
        @(negedge clk);
        bus_read(2'd2, rdata); check_val("go_bit0_zero", rdata, 32'h1);

        // Writes while busy are ignored; N=6 -> 720
        bus_write(2'd0, 32'd6);
        bus_write(2'd1, 32'd1);
        @(negedge clk);
        bus_write(2'd0, 32'd7);
        bus_write(2'd1, 32'd1);
        bus_read(2'd0, rdata); check_val("n_frozen_busy", rdata, 32'd6);
        check_val("core_n_frozen", core_n, 32'd6);
        core_finish(1'b0, 32'd720);
        check_val("no_second_go", go_cnt - go_base, 32'd1);
        bus_read(2'd3, rdata); check_val("result_720", rdata, 32'd720);

        // RO writes ignored
        bus_write(2'd3, 32'h55);
        bus_read(2'd3, rdata); check_val("result_ro", rdata, 32'd720);

        // Same-cycle read and write of N returns pre-write value
        re = 1'b1; we = 1'b1; addr = 2'd0; wd = 32'd9;
        @(negedge clk);
        re = 1'b0; we = 1'b0; wd = '0;
        check_val("rw_same_cycle_old", rd, 32'd6);
        bus_read(2'd0, rdata); check_val("rw_same_cycle_new", rdata, 32'd9);

        // Async reset mid-WAIT
        bus_write(2'd0, 32'd5);
        bus_write(2'd1, 32'd1);
        @(negedge clk);
        bus_read(2'd0, rdata);
        #2 rst = 1'b1;
        #1;
        check_val("arst_rd", rd, 32'd0);
        check_val("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_val("arst_core_n", core_n, 32'd0);
        check_val("arst_go", {31'd0, core_go}, 32'd0);
        check_val("arst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        core_finish(1'b0, 32'd120);
        bus_read(2'd2, rdata); check_val("status_after_arst", rdata, 32'd0);
        bus_read(2'd3, rdata); check_val("late_done_ignored", rdata, 32'd0);

`ifdef FACT_IRQ_EN
        bus_write(2'd2, 32'h100);
        bus_read(2'd2, rdata); check_val("irq_en_set", rdata, 32'h100);
        bus_write(2'd0, 32'd4);
        bus_write(2'd1, 32'd1);
        @(negedge clk);
        check_val("irq_low_busy", {31'd0, irq}, 32'd0);
        core_finish(1'b0, 32'd24);
        check_val("irq_after_done", {31'd0, irq}, 32'd1);
        bus_read(2'd2, rdata); check_val("status_irq_done", rdata, 32'h101);
        bus_read(2'd3, rdata); check_val("result_24", rdata, 32'd24);
        bus_write(2'd1, 32'd1);
        check_val("irq_cleared_go", {31'd0, irq}, 32'd0);
        @(negedge clk);
        core_finish(1'b0, 32'd24);
        check_val("irq_again", {31'd0, irq}, 32'd1);
        bus_write(2'd2, 32'h0);
        check_val("irq_cleared_en0", {31'd0, irq}, 32'd0);
`else
        bus_write(2'd2, 32'h107);
        bus_read(2'd2, rdata); check_val("status_write_ignored", rdata, 32'd0);
        bus_write(2'd0, 32'd4);
        bus_write(2'd1, 32'd1);
        @(negedge clk);
        core_finish(1'b0, 32'd24);
        check_val("irq_tied_low", {31'd0, irq}, 32'd0);
        bus_read(2'd2, rdata); check_val("status_no_irq_en", rdata, 32'h1);
        bus_read(2'd3, rdata); check_val("result_24", rdata, 32'd24);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
